// File: rtl/decoder_3e_if.sv
// decoder_3e_if: select/enable in, one-hot word plus valid out.
// Ports: n/ena (master->slave), e/vld (slave->master).
interface decoder_3e_if #(
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0]      n;
  logic                  ena;
  logic [(1<<SEL_W)-1:0] e;
  logic                  vld;

  modport master (
    output n,
    output ena,
    input  e,
    input  vld
  );

  modport slave (
    input  n,
    input  ena,
    output e,
    output vld
  );
endinterface

// File: rtl/decoder_3e.sv
// decoder_3e: registered SEL_W-to-2^SEL_W one-hot decoder with enable.
// Ports: clk, rst_n (async low), bus.slave (n, ena -> e, vld).
module decoder_3e #(
  parameter int SEL_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  decoder_3e_if.slave  bus
);
  localparam int OUT_W = 1 << SEL_W;

  logic [OUT_W-1:0] e_d;
  logic [OUT_W-1:0] e_q;
  logic             vld_d;
  logic             vld_q;

  // ena gates every bit, so an unknown n while disabled
  // cannot leak into the registered word.
  always_comb begin
    e_d   = '0;
    vld_d = bus.ena;
    for (int k = 0; k < OUT_W; k++) begin
      e_d[k] = bus.ena & (bus.n == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      e_q   <= e_d;
      vld_q <= vld_d;
    end
  end

  assign bus.e   = e_q;
  assign bus.vld = vld_q;
endmodule

// File: tb/tb_decoder_3e.sv
// tb_decoder_3e: vector table, corner sequences and random
// stimulus against a reference decode model.
module tb_decoder_3e;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  decoder_3e_if #(.SEL_W(3)) bus ();

  decoder_3e #(.SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] n;
    logic       ena;
    logic [7:0] e;
    logic       vld;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [7:0] ref_e(int nv, bit en);
    int v;
    v = en ? (2 ** nv) : 0;
    return 8'(v);
  endfunction

  task automatic check(string name, logic [7:0] xe, logic xv);
    tests++;
    if (bus.e !== xe || bus.vld !== xv) begin
      fails++;
      $display("FAIL %s: e=%b vld=%b, want e=%b vld=%b",
               name, bus.e, bus.vld, xe, xv);
    end
  endtask

  task automatic apply(logic [2:0] nv, logic en);
    bus.n   = nv;
    bus.ena = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs[0]  = '{3'd0, 1'b1, 8'b00000001, 1'b1};
    vecs[1]  = '{3'd1, 1'b1, 8'b00000010, 1'b1};
    vecs[2]  = '{3'd2, 1'b1, 8'b00000100, 1'b1};
    vecs[3]  = '{3'd3, 1'b1, 8'b00001000, 1'b1};
    vecs[4]  = '{3'd4, 1'b1, 8'b00010000, 1'b1};
    vecs[5]  = '{3'd5, 1'b1, 8'b00100000, 1'b1};
    vecs[6]  = '{3'd6, 1'b1, 8'b01000000, 1'b1};
    vecs[7]  = '{3'd7, 1'b1, 8'b10000000, 1'b1};
    vecs[8]  = '{3'd7, 1'b0, 8'b00000000, 1'b0};
    vecs[9]  = '{3'd7, 1'b0, 8'b00000000, 1'b0};
    vecs[10] = '{3'd0, 1'b1, 8'b00000001, 1'b1};
    vecs[11] = '{3'd5, 1'b0, 8'b00000000, 1'b0};

    // Reset held with a live code: outputs stay zero.
    rst_n   = 1'b0;
    bus.n   = 3'd5;
    bus.ena = 1'b1;
    #1;
    check("reset_imm", 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 8'h00, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rel", 8'b00100000, 1'b1);

    // Sweep, disable, re-enable from the table.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].n, vecs[i].ena);
      check($sformatf("vec%0d", i), vecs[i].e, vecs[i].vld);
    end

    // Unknown select while disabled must decode to zero.
    bus.n = 3'bxxx;
    bus.ena = 1'b0;
    @(posedge clk);
    #1;
    check("xmask", 8'h00, 1'b0);

    // Async reset pulse between edges mid-sweep.
    apply(3'd2, 1'b1);
    check("mid_pre", 8'b00000100, 1'b1);
    bus.n = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_hold", 8'h00, 1'b0);
    bus.n = 3'd6;
    @(posedge clk);
    #1;
    check("mid_resume", 8'b01000000, 1'b1);

    // Random stream against the reference decode.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] rn;
      logic       re;
      rn = 3'($urandom_range(0, 7));
      re = 1'($urandom_range(0, 3) != 0);
      apply(rn, re);
      check("rand", ref_e(int'(rn), re), re);
      tests++;
      if ($countones(bus.e) != int'(bus.vld)) begin
        fails++;
        $display("FAIL onehot: e=%b vld=%b, want popcount=vld",
                 bus.e, bus.vld);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
